key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of debounced key inputs served (2..16).
REQ-002 SHALL have parameter LONG_CYCLES, default 100000000, held-press cycles before a LONG event (1 s at 100 MHz).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_db  input  NUM_KEYS  debounced key levels, 1 = pressed, synchronous to clk.
REQ-006 SHALL have port evt_valid  output  1  event offered.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-008 SHALL have port evt_id  output  clog2(NUM_KEYS)  index of key owning the event.
REQ-009 SHALL have port evt_type  output  2  01 PRESS, 10 RELEASE, 11 LONG; 00 never offered.
REQ-010 SHALL have port ovf  output  1  sticky flag: an event was dropped.
REQ-011 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 SHALL register key_db into prev each cycle; rising edge (key_db & ~prev) -> PRESS, falling edge -> RELEASE for that key.
REQ-013 SHALL skip edge detection in the first cycle after reset release (prev loads key_db, no events), so keys held through reset generate no PRESS.
REQ-014 SHALL keep one pending slot per key (valid + type); a detected event sets the slot at the same clock edge.
REQ-015 SHALL, when a key's slot is valid and not being granted that cycle, drop the new event, keep the old one, and set ovf.
REQ-016 SHALL, when a key's slot is granted in the same cycle a new event for that key is detected, store the new event (no drop).
REQ-017 SHALL arbitrate pending slots round-robin, search starting at last granted index + 1, wrapping NUM_KEYS-1 -> 0.
REQ-018 SHALL use states IDLE (evt_valid=0) and OFFER (evt_valid=1); IDLE -> OFFER when any slot pending, loading winner id/type into output registers and clearing that slot.
REQ-019 SHALL hold evt_id/evt_type stable in OFFER until evt_valid & evt_ready.
REQ-020 SHALL, on handshake, load the next winner in the same cycle and stay in OFFER if any slot pending, else go IDLE (throughput one event per cycle).
REQ-021 SHALL present an event with evt_valid high 2 cycles after the key_db change when the arbiter is idle.
REQ-022 SHALL, per key, count cycles while pressed; at count == LONG_CYCLES-1 raise one LONG event, then saturate until release; count clears on release.
REQ-023 SHALL size hold counters clog2(LONG_CYCLES+1) bits with no wrap.
REQ-024 SHALL give ovf_clr priority below a same-cycle drop (drop wins, ovf stays 1).

Reset
REQ-025 SHALL on rst asynchronously clear: evt_valid=0, evt_id=0, evt_type=00, ovf=0, all pending slots, hold counters, prev, last-grant pointer (=NUM_KEYS-1), state=IDLE.
REQ-026 SHALL discard any offered or pending event when rst asserts mid-operation; nothing is replayed after release.

Configuration
REQ-027 SHALL compile hold counters and LONG events only when KEY_LONG_PRESS_EN is defined.
REQ-028 SHALL, without KEY_LONG_PRESS_EN, never produce evt_type 11, ignore LONG_CYCLES, and instantiate no counters.

Structure
REQ-029 SHALL place evt_type encodings (EVT_PRESS, EVT_RELEASE, EVT_LONG) and the state enum in package key_evt_pkg.
REQ-030 SHALL implement per-key edge detect, hold counter, and pending slot in sub-module key_evt_track, instantiated NUM_KEYS times; arbiter and FSM stay in key_event_ctrl.

Verification (NUM_KEYS=4, LONG_CYCLES=16, KEY_LONG_PRESS_EN defined unless noted)
REQ-031 SHALL cover: key_db[2] 0->1, evt_ready=1 -> evt_valid=1 two cycles later with evt_id=2, evt_type=01 for one cycle.
REQ-032 SHALL cover: key_db 0000->1111 same cycle, evt_ready=1 -> four back-to-back PRESS events ids 0,1,2,3, then evt_valid=0.
REQ-033 SHALL cover: hold key_db[1] for 20 cycles then release -> PRESS id1, LONG id1 exactly once, RELEASE id1; repeat without macro -> PRESS and RELEASE only.
REQ-034 SHALL cover: evt_ready=0, key_db[0] toggles 0->1->0 -> PRESS held stable, RELEASE kept pending, third edge 0->1 dropped, ovf=1; ovf_clr pulse -> ovf=0.
REQ-035 SHALL cover: key_db=0101 held through reset release -> no events; rst pulse during OFFER -> evt_valid=0 immediately, no event after release.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Event type encodings and arbiter FSM states for key_event_ctrl.
// No logic; no latency and no backpressure.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } evt_type_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/key_evt_track.sv
// Per-key edge detect, optional hold counter (KEY_LONG_PRESS_EN) and one-deep pending slot; event lands in slot 1 cycle after key change.
// Backpressure: a new event hitting an occupied, ungranted slot is dropped and flagged.
module key_evt_track
    import key_evt_pkg::*;
#(
    parameter int LONG_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       key,
    input  logic       grant,
    output logic       pend,
    output logic [1:0] pend_type,
    output logic       drop
);

    logic       prev;
    logic       rise;
    logic       fall;
    logic       long_evt;
    logic       new_vld;
    logic [1:0] new_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= key;
    end

    // arm is low for the first cycle after reset so held keys only prime prev
    assign rise = arm & key & ~prev;
    assign fall = arm & ~key & prev;

`ifdef KEY_LONG_PRESS_EN
    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_HIT = CW'(LONG_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturates at LONG_CYCLES so the LONG event fires once per press
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   cnt <= '0;
        else if (!key)                             cnt <= '0;
        else if (arm && prev && (cnt != CNT_MAX))  cnt <= cnt + CW'(1);
    end

    assign long_evt = arm & key & prev & (cnt == CNT_HIT);
`else
    assign long_evt = 1'b0;
`endif

    always_comb begin
        new_vld  = rise | fall | long_evt;
        new_type = EVT_LONG;
        if (rise)      new_type = EVT_PRESS;
        else if (fall) new_type = EVT_RELEASE;
    end

    assign drop = new_vld & pend & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_type <= EVT_NONE;
        end else if (new_vld && !drop) begin
            pend      <= 1'b1;
            pend_type <= new_type;
        end else if (grant) begin
            pend      <= 1'b0;
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key trackers feed a round-robin arbiter, event valid 2 cycles after key change, 1 event/cycle; LONG events need KEY_LONG_PRESS_EN.
// Backpressure: output held until evt_ready; per-key events arriving while that key's slot is full are dropped and set sticky ovf.
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         key_db,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_id,
    output logic [1:0]                  evt_type,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int IDW = $clog2(NUM_KEYS);

    state_t                     state;
    state_t                     state_nxt;
    logic                       arm;
    logic                       load;
    logic [NUM_KEYS-1:0]        pend;
    logic [NUM_KEYS-1:0][1:0]   pend_type;
    logic [NUM_KEYS-1:0]        drop;
    logic [NUM_KEYS-1:0]        grant;
    logic [IDW-1:0]             last_id;
    logic [IDW-1:0]             win_id;
    logic                       win_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) arm <= 1'b0;
        else     arm <= 1'b1;
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_trk
        key_evt_track #(
            .LONG_CYCLES (LONG_CYCLES)
        ) u_trk (
            .clk       (clk),
            .rst       (rst),
            .arm       (arm),
            .key       (key_db[g]),
            .grant     (grant[g]),
            .pend      (pend[g]),
            .pend_type (pend_type[g]),
            .drop      (drop[g])
        );
    end

    // Round-robin search starts just past the last granted key
    always_comb begin
        int             j;
        logic [IDW-1:0] sel;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_KEYS; k++) begin
            j   = (int'(last_id) + k) % NUM_KEYS;
            sel = IDW'(j);
            if (!win_found && pend[sel]) begin
                win_found = 1'b1;
                win_id    = sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load      = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (win_found) load = 1'b1;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            grant[i] = load && (win_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            evt_id   <= '0;
            evt_type <= EVT_NONE;
            last_id  <= IDW'(NUM_KEYS - 1);
        end else begin
            state <= state_nxt;
            if (load) begin
                evt_id   <= win_id;
                evt_type <= pend_type[win_id];
                last_id  <= win_id;
            end
        end
    end

    assign evt_valid = (state == OFFER);

    // A drop in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (|drop)   ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl (NUM_KEYS=4, LONG_CYCLES=16); LONG expectations follow KEY_LONG_PRESS_EN.
module tb_key_event_ctrl;
    import key_evt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_db;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic       ovf;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    logic [1:0] log_id[$];
    logic [1:0] log_type[$];

    key_event_ctrl #(
        .NUM_KEYS    (4),
        .LONG_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_db    (key_db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so a negedge sample sees the next handshake
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            log_id.push_back(evt_id);
            log_type.push_back(evt_type);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [3:0] keys);
        rst       = 1'b1;
        key_db    = keys;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_id.delete();
        log_type.delete();
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_db    = 4'b1111;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick();
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        total++; if (evt_type !== 2'b00) begin bad++; $display("FAIL reset_type: got %b want 00", evt_type); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_single();
        reset_dut(4'b0000);
        key_db = 4'b0100;
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", evt_valid); end
        tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        total++; if (evt_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", evt_id); end
        total++; if (evt_type !== EVT_PRESS) begin bad++; $display("FAIL single_type: got %b want 01", evt_type); end
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_oneshot: got %b want 0", evt_valid); end
        key_db = 4'b0000;
        repeat (4) tick();
        total++;
        if (log_id.size() !== 2) begin
            bad++; $display("FAIL single_count: got %0d want 2", log_id.size());
        end else begin
            total++; if (log_id[1] !== 2'd2) begin bad++; $display("FAIL single_rel_id: got %0d want 2", log_id[1]); end
            total++; if (log_type[1] !== EVT_RELEASE) begin bad++; $display("FAIL single_rel_type: got %b want 10", log_type[1]); end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut(4'b0000);
        key_db = 4'b1111;
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_early: got %b want 0", evt_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %b want 1", i, evt_valid); end
            total++; if (evt_id !== 2'(i)) begin bad++; $display("FAIL b2b_id%0d: got %0d want %0d", i, evt_id, i); end
            total++; if (evt_type !== EVT_PRESS) begin bad++; $display("FAIL b2b_type%0d: got %b want 01", i, evt_type); end
        end
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", evt_valid); end
        key_db = 4'b0000;
        repeat (8) tick();
        total++;
        if (log_id.size() !== 8) begin
            bad++; $display("FAIL b2b_count: got %0d want 8", log_id.size());
        end else begin
            for (int i = 4; i < 8; i++) begin
                total++; if (log_id[i] !== 2'(i - 4)) begin bad++; $display("FAIL b2b_rel_id%0d: got %0d want %0d", i, log_id[i], i - 4); end
                total++; if (log_type[i] !== EVT_RELEASE) begin bad++; $display("FAIL b2b_rel_type%0d: got %b want 10", i, log_type[i]); end
            end
        end
    endtask

    task automatic test_long_press();
        logic [1:0] exp_type[$];
`ifdef KEY_LONG_PRESS_EN
        exp_type = '{EVT_PRESS, EVT_LONG, EVT_RELEASE};
`else
        exp_type = '{EVT_PRESS, EVT_RELEASE};
`endif
        reset_dut(4'b0000);
        key_db = 4'b0010;
        repeat (20) tick();
        key_db = 4'b0000;
        repeat (6) tick();
        total++;
        if (log_id.size() !== exp_type.size()) begin
            bad++; $display("FAIL long_count: got %0d want %0d", log_id.size(), exp_type.size());
        end else begin
            for (int i = 0; i < exp_type.size(); i++) begin
                total++; if (log_id[i] !== 2'd1) begin bad++; $display("FAIL long_id%0d: got %0d want 1", i, log_id[i]); end
                total++; if (log_type[i] !== exp_type[i]) begin bad++; $display("FAIL long_type%0d: got %b want %b", i, log_type[i], exp_type[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        reset_dut(4'b0000);
        evt_ready = 1'b0;
        key_db    = 4'b0001;
        tick();
        tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL ovf_offer: got %b want 1", evt_valid); end
        total++; if (evt_type !== EVT_PRESS) begin bad++; $display("FAIL ovf_offer_type: got %b want 01", evt_type); end
        key_db = 4'b0000;
        tick();
        key_db  = 4'b0001;
        ovf_clr = 1'b1;
        tick();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_drop_beats_clr: got %b want 1", ovf); end
        total++; if (evt_type !== EVT_PRESS) begin bad++; $display("FAIL ovf_hold_type: got %b want 01", evt_type); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL ovf_hold_id: got %0d want 0", evt_id); end
        ovf_clr = 1'b0;
        tick();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        ovf_clr = 1'b1;
        tick();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL ovf_kept_valid: got %b want 1", evt_valid); end
        total++; if (evt_type !== EVT_RELEASE) begin bad++; $display("FAIL ovf_kept_type: got %b want 10", evt_type); end
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", evt_valid); end
        key_db = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_reset_hold();
        int seen;
        rst       = 1'b1;
        key_db    = 4'b0101;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_id.delete();
        log_type.delete();
        seen = 0;
        repeat (8) begin
            tick();
            if (evt_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL hold_no_valid: got %0d cycles want 0", seen); end
        total++; if (log_id.size() !== 0) begin bad++; $display("FAIL hold_no_events: got %0d want 0", log_id.size()); end

        evt_ready = 1'b0;
        key_db    = 4'b0111;
        tick();
        tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL midrst_offer: got %b want 1", evt_valid); end
        total++; if (evt_id !== 2'd1) begin bad++; $display("FAIL midrst_id: got %0d want 1", evt_id); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL midrst_async: got %b want 0", evt_valid); end
        total++; if (evt_type !== 2'b00) begin bad++; $display("FAIL midrst_type: got %b want 00", evt_type); end
        tick();
        tick();
        rst       = 1'b0;
        evt_ready = 1'b1;
        log_id.delete();
        log_type.delete();
        seen = 0;
        repeat (8) begin
            tick();
            if (evt_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_replay: got %0d cycles want 0", seen); end
        total++; if (log_id.size() !== 0) begin bad++; $display("FAIL midrst_no_events: got %0d want 0", log_id.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        key_db    = 4'b0000;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_long_press();
        test_overflow();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
